pipe_exe_mem_div: RTL

- EXE/MEM pipeline register for the static pipeline CPU. It latches every EXE-stage result and control field into M-stage outputs.
- It embeds the multi-cycle iterative divider that produces quotient/remainder (HI/LO sources) for DIV/DIVU.
- While a divide is in flight it asserts stall to freeze PC/IF/ID/EXE and feeds bubbles into MEM.

---
 rtl/pipe_exe_mem_div.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_exe_mem_div.sv
`default_nettype none
// ============================================================================
// Module   : pipe_exe_mem_div
// Brief    : EXE/MEM pipeline register with an embedded iterative divider
//            that stalls the front end while DIV/DIVU is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_exe_mem_div #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             Ediv,
  input  logic [WIDTH-1:0] Ealu,
  input  logic [WIDTH-1:0] Ea,
  input  logic [WIDTH-1:0] Eb,
  input  logic [WIDTH-1:0] Epc4,
  input  logic [WIDTH-1:0] Ecp0,
  input  logic [WIDTH-1:0] Ehi,
  input  logic [WIDTH-1:0] Elo,
  input  logic [4:0]       Ern,
  input  logic [2:0]       Erfsource,
  input  logic [1:0]       Ecuttersource,
  input  logic [1:0]       Ehisource,
  input  logic [1:0]       Elosource,
  input  logic             Esign,
  input  logic             EisGoto,
  input  logic             Ew_dm,
  input  logic             Ew_rf,
  input  logic             Ew_hi,
  input  logic             Ew_lo,
  output logic [WIDTH-1:0] Malu,
  output logic [WIDTH-1:0] Mb,
  output logic [WIDTH-1:0] Mpc4,
  output logic [WIDTH-1:0] Mcp0,
  output logic [WIDTH-1:0] Mhi,
  output logic [WIDTH-1:0] Mlo,
  output logic [WIDTH-1:0] Mq,
  output logic [WIDTH-1:0] Mr,
  output logic [4:0]       Mrn,
  output logic [2:0]       Mrfsource,
  output logic [1:0]       Mcuttersource,
  output logic [1:0]       Mhisource,
  output logic [1:0]       Mlosource,
  output logic             Msign,
  output logic             MisGoto,
  output logic             Mw_dm,
  output logic             Mw_rf,
  output logic             Mw_hi,
  output logic             Mw_lo,
  output logic             stall
);

  localparam int         c_CW   = $clog2(DIV_ITERS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV_ITERS - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dvs_zero;

  logic             w_accept;
  logic             w_load;
  logic             w_load_qr;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (Ediv && !flush) w_next_state = c_BUSY;
      c_BUSY: begin
        if (flush)               w_next_state = c_IDLE;
        else if (r_cnt == c_LAST) w_next_state = c_DONE;
      end
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic: stall and M-register load selects
  always_comb begin
    stall     = 1'b0;
    w_load    = 1'b0;
    w_load_qr = 1'b0;
    if (!rst) begin
      case (r_state)
        c_IDLE: begin
          stall  = Ediv & ~flush;
          w_load = ~Ediv & ~flush;
        end
        c_BUSY: stall = 1'b1;
        c_DONE: begin
          w_load    = ~flush;
          w_load_qr = ~flush;
        end
        default: ;
      endcase
    end
  end

  assign w_accept = (r_state == c_IDLE) && Ediv && !flush;
  assign w_abs_a  = (Esign && Ea[WIDTH-1]) ? -Ea : Ea;
  assign w_abs_b  = (Esign && Eb[WIDTH-1]) ? -Eb : Eb;

  // One restoring step: bring down the next dividend bit, try the subtract
  assign w_shifted = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_dvs};

  // A zero divisor reports all-ones / raw dividend regardless of signedness
  assign w_q_fix = r_dvs_zero ? {WIDTH{1'b1}} : (r_qneg ? -r_dvd : r_dvd);
  assign w_r_fix = r_dvs_zero ? Ea            : (r_rneg ? -r_rem : r_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_dvs_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_dvd      <= w_abs_a;
      r_dvs      <= w_abs_b;
      r_rem      <= '0;
      r_qneg     <= Esign & (Ea[WIDTH-1] ^ Eb[WIDTH-1]);
      r_rneg     <= Esign & Ea[WIDTH-1];
      r_dvs_zero <= (Eb == '0);
    end else if (r_state == c_BUSY && !flush) begin
      r_cnt <= r_cnt + c_CW'(1);
      r_dvd <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
      r_rem <= w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end else begin
      r_cnt <= '0;
    end
  end

  // EXE/MEM register; anything that is neither a load nor a reset is a bubble
  always_ff @(posedge clk) begin
    if (rst || !w_load) begin
      Malu          <= '0;
      Mb            <= '0;
      Mpc4          <= '0;
      Mcp0          <= '0;
      Mhi           <= '0;
      Mlo           <= '0;
      Mq            <= '0;
      Mr            <= '0;
      Mrn           <= '0;
      Mrfsource     <= '0;
      Mcuttersource <= '0;
      Mhisource     <= '0;
      Mlosource     <= '0;
      Msign         <= 1'b0;
      MisGoto       <= 1'b0;
      Mw_dm         <= 1'b0;
      Mw_rf         <= 1'b0;
      Mw_hi         <= 1'b0;
      Mw_lo         <= 1'b0;
    end else begin
      Malu          <= Ealu;
      Mb            <= Eb;
      Mpc4          <= Epc4;
      Mcp0          <= Ecp0;
      Mhi           <= Ehi;
      Mlo           <= Elo;
      Mrn           <= Ern;
      Mrfsource     <= Erfsource;
      Mcuttersource <= Ecuttersource;
      Mhisource     <= Ehisource;
      Mlosource     <= Elosource;
      Msign         <= Esign;
      MisGoto       <= EisGoto;
      Mw_dm         <= Ew_dm;
      Mw_rf         <= Ew_rf;
      Mw_hi         <= Ew_hi;
      Mw_lo         <= Ew_lo;
      if (w_load_qr) begin
        Mq <= w_q_fix;
        Mr <= w_r_fix;
      end
    end
  end

endmodule
`default_nettype wire
